fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage placed directly upstream of the bitty control unit.
- Keeps a program counter and reads 16-bit instruction words from a synchronous instruction memory with 1-cycle read latency.
- Presents each word on `instruction` and holds it stable, with `run` asserted, until the control unit pulses `done`. Then it advances the PC.
- A configurable halt word stops fetching.

Parameters:
- ADDR_W, 8, width of PC and memory address; PC wraps modulo 2^ADDR_W.
- INSTR_W, 16, instruction width; must match control unit.
- START_ADDR, 0, PC value after reset.
- HALT_INSTR, 16'hFFFF, fetched word that stops the unit instead of being issued.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  permits starting a new fetch; sampled only in IDLE and after each completed instruction.
- load_pc  input  1  one-cycle request to overwrite PC; honoured only in IDLE or HALTED.
- load_addr  input  ADDR_W  new PC value for load_pc.
- mem_addr  output  ADDR_W  instruction memory address, registered.
- mem_rd_en  output  1  memory read strobe, one cycle per fetch.
- mem_rdata  input  INSTR_W  memory data, valid the cycle after mem_rd_en.
- instruction  output  INSTR_W  instruction to control unit, registered, stable throughout ISSUE.
- run  output  1  instruction valid / execute request to control unit.
- done  input  1  one-cycle completion pulse from control unit.
- pc  output  ADDR_W  address of the instruction currently held or next to fetch.
- halted  output  1  high while in HALTED.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=START_ADDR, mem_addr=START_ADDR.
  - mem_rd_en=0, run=0, halted=0, instruction=0.
- Reset mid-ISSUE drops `run` immediately; the control unit's own reset handles its side.
- States: IDLE, FETCH, WAIT_MEM, ISSUE, HALTED.
- IDLE:
  - load_pc=1 sets pc=mem_addr=load_addr and stays in IDLE. load_pc has priority over enable in the same cycle.
  - Otherwise enable=1 goes to FETCH.
- FETCH, 1 cycle: mem_rd_en=1, mem_addr=pc; next state WAIT_MEM.
- WAIT_MEM, 1 cycle: mem_rd_en=0.
  - mem_rdata==HALT_INSTR: instruction is not updated, go to HALTED (halted=1 next cycle).
  - Otherwise instruction<=mem_rdata, run<=1, go to ISSUE.
- ISSUE: run held at 1 and instruction unchanged until done=1 is sampled. On that edge:
  - run<=0 and pc<=pc+1, wrapping 2^ADDR_W-1 -> 0.
  - enable=1 goes to FETCH; enable=0 goes to IDLE.
  - run falls on the same edge at which the control unit returns to its first step, so it idles there.
- done while not in ISSUE is ignored.
- load_pc during ISSUE, FETCH or WAIT_MEM is ignored.
- HALTED: run=0, pc keeps the halt word's address.
  - Exit only via load_pc=1, which sets pc, clears halted and goes to IDLE.
  - Reset also exits HALTED.
- Latency:
  - FETCH entry to run=1 is 2 cycles.
  - done sampled to next mem_rd_en (enable=1) is 1 cycle.
  - Minimum loop with a 4-cycle control unit is about 7 cycles per instruction.
- Invariant: run and mem_rd_en are never high in the same cycle.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, WAIT_MEM, ISSUE, HALTED);
  - INSTR_W=16;
  - the instruction field positions used downstream: dst [15:13], src [12:10], alu_sel [4:2];
  - the default HALT_INSTR.
- No sub-module; PC register and FSM are a single block.
- The bench supplies a behavioural synchronous ROM model.

Test Plan:
- Reset, ROM[0]=16'h2408, enable=1, done pulsed 2 cycles after run rises:
  - mem_rd_en pulses addr 0;
  - run=1 with instruction=16'h2408 two cycles after FETCH entry;
  - pc=1 after done.
- done delayed 10 cycles: instruction and run stay constant for all 10 cycles, and no mem_rd_en occurs.
- ADDR_W=2, ROM 0..3 non-halt, continuous enable: addresses 0,1,2,3,0 fetched in order, pc wraps 3->0.
- ROM[2]=16'hFFFF: after issuing addr 0,1, the unit enters HALTED with halted=1, run never asserted for addr 2, and pc=2. Then load_pc=1, load_addr=0: halted=0, state IDLE.
- enable=0 asserted during ISSUE: after done the unit returns to IDLE with no further mem_rd_en. Re-asserting enable fetches pc+1.
- reset pulsed low mid-ISSUE, asynchronously between edges: run=0 and pc=START_ADDR immediately, without waiting for a clock edge. A spurious done afterwards changes nothing.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the bitty control unit it feeds.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W            = 16;
  localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;

  // Instruction field positions decoded downstream
  localparam int unsigned DST_MSB     = 15;
  localparam int unsigned DST_LSB     = 13;
  localparam int unsigned SRC_MSB     = 12;
  localparam int unsigned SRC_LSB     = 10;
  localparam int unsigned ALU_SEL_MSB = 4;
  localparam int unsigned ALU_SEL_LSB = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    ISSUE    = 3'd3,
    HALTED   = 3'd4
  } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port plus the issue handshake towards the control unit.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd_en;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               run;
  logic               done;

  modport master (
    output mem_addr, mem_rd_en, instruction, run,
    input  mem_rdata, done
  );

  modport slave (
    input  mem_addr, mem_rd_en, instruction, run,
    output mem_rdata, done
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register plus fetch/issue FSM in front of the control unit.
// Words come from a 1-cycle-latency synchronous memory; a halt word parks the unit.
module fetch_unit #(
  parameter int unsigned        ADDR_W     = 8,
  parameter int unsigned        INSTR_W    = fetch_unit_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [INSTR_W-1:0] HALT_INSTR = fetch_unit_pkg::HALT_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  fetch_unit_if.master      bus
);
  import fetch_unit_pkg::*;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_en_q, rd_en_d;
  logic               run_q, run_d;
  logic               halted_q, halted_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_inc;

  assign pc_inc = pc_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= START_ADDR;
      addr_q   <= START_ADDR;
      rd_en_q  <= 1'b0;
      run_q    <= 1'b0;
      halted_q <= 1'b0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      run_q    <= run_d;
      halted_q <= halted_d;
      instr_q  <= instr_d;
    end
  end

  // Next-state and next-output logic; the read strobe is raised on entry to FETCH
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    rd_en_d  = 1'b0;
    run_d    = run_q;
    halted_d = halted_q;
    instr_d  = instr_q;
    unique case (state_q)
      IDLE: begin
        if (load_pc) begin
          pc_d   = load_addr;
          addr_d = load_addr;
        end else if (enable) begin
          state_d = FETCH;
          rd_en_d = 1'b1;
          addr_d  = pc_q;
        end
      end
      FETCH: state_d = WAIT_MEM;
      WAIT_MEM: begin
        if (bus.mem_rdata == HALT_INSTR) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          state_d = ISSUE;
          instr_d = bus.mem_rdata;
          run_d   = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.done) begin
          run_d = 1'b0;
          pc_d  = pc_inc;
          if (enable) begin
            state_d = FETCH;
            rd_en_d = 1'b1;
            addr_d  = pc_inc;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALTED: begin
        if (load_pc) begin
          state_d  = IDLE;
          pc_d     = load_addr;
          addr_d   = load_addr;
          halted_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr    = addr_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.instruction = instr_q;
  assign bus.run         = run_q;
  assign pc              = pc_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus multi-cycle corner sequences.
module tb_fetch_unit;
  localparam int unsigned AW = 2;
  localparam int unsigned IW = 16;
  localparam int unsigned NV = 19;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          load_pc = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [AW-1:0] pc;
  logic          halted;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [IW-1:0] rom [4];

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .START_ADDR(2'd0), .HALT_INSTR(16'hFFFF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .load_pc(load_pc),
    .load_addr(load_addr), .pc(pc), .halted(halted), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous ROM, one cycle read latency
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= rom[bus.mem_addr];

  typedef struct {
    logic          en;
    logic          ld;
    logic [AW-1:0] la;
    logic          dn;
    logic          rd;
    logic [AW-1:0] addr;
    logic          run;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          h;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic en, input logic ld, input logic [AW-1:0] la,
                              input logic dn, input logic rd, input logic [AW-1:0] addr,
                              input logic run, input logic [IW-1:0] instr,
                              input logic [AW-1:0] p, input logic h);
    vec_t v;
    v.en = en; v.ld = ld; v.la = la; v.dn = dn; v.rd = rd;
    v.addr = addr; v.run = run; v.instr = instr; v.pc = p; v.h = h;
    return v;
  endfunction

  always @(negedge clk) chk("run_rd_exclusive", 32'(bus.run & bus.mem_rd_en), 32'd0);

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; load_pc = 1'b0; load_addr = '0; bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("reset_addr", 32'(bus.mem_addr), 32'd0);
    chk("reset_run", 32'(bus.run), 32'd0);
    chk("reset_instr", 32'(bus.instruction), 32'd0);
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    reset = 1'b1;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!bus.run && n < 20) begin @(posedge clk); #1; n++; end
    chk("run_rise", 32'(bus.run), 32'd1);
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b0;
  endtask

  initial begin
    //           en    ld    la    dn    rd    addr  run   instr     pc    h
    vecs[0]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 2'd0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h2408, 2'd0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h2408, 2'd0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, 16'h2408, 2'd1, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h2408, 2'd1, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b1, 16'h1234, 2'd1, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 16'h1234, 2'd2, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h1234, 2'd2, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 16'h1234, 2'd2, 1'b1);
    vecs[10] = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 16'h1234, 2'd2, 1'b1);
    vecs[11] = mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 1'b0, 16'h1234, 2'd3, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd1, 1'b0, 16'h1234, 2'd1, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 16'h1234, 2'd1, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b0, 16'h1234, 2'd1, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b1, 16'h1234, 2'd1, 1'b0);
    vecs[16] = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h1234, 2'd2, 1'b0);
    vecs[17] = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 16'h1234, 2'd2, 1'b0);
    vecs[18] = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 16'h1234, 2'd2, 1'b0);

    // Basic fetch/issue, halt word, load_pc priority and ignore rules, enable drop
    rom[0] = 16'h2408; rom[1] = 16'h1234; rom[2] = 16'hFFFF; rom[3] = 16'h0042;
    do_reset();
    for (int i = 0; i < int'(NV); i++) begin
      enable = vecs[i].en; load_pc = vecs[i].ld; load_addr = vecs[i].la; bus.done = vecs[i].dn;
      @(posedge clk); #1;
      chk($sformatf("v%0d_rd_en", i), 32'(bus.mem_rd_en), 32'(vecs[i].rd));
      chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_run", i), 32'(bus.run), 32'(vecs[i].run));
      chk($sformatf("v%0d_instr", i), 32'(bus.instruction), 32'(vecs[i].instr));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].h));
    end

    // Long-running instruction: issue held, no further reads
    rom[0] = 16'h2408;
    do_reset();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_run();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_run", 32'(bus.run), 32'd1);
      chk("hold_instr", 32'(bus.instruction), 32'h2408);
      chk("hold_no_rd", 32'(bus.mem_rd_en), 32'd0);
    end
    pulse_done();
    chk("hold_pc_after_done", 32'(pc), 32'd1);
    chk("hold_run_after_done", 32'(bus.run), 32'd0);

    // PC wraps 3 -> 0 with continuous enable
    rom[0] = 16'h1000; rom[1] = 16'h1001; rom[2] = 16'h1002; rom[3] = 16'h1003;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      while (!bus.mem_rd_en && n < 20) begin @(posedge clk); #1; n++; end
      chk("wrap_rd_en", 32'(bus.mem_rd_en), 32'd1);
      chk("wrap_addr", 32'(bus.mem_addr), 32'(k % 4));
      wait_run();
      chk("wrap_instr", 32'(bus.instruction), 32'(16'h1000 + 16'(k % 4)));
      if (k == 4) enable = 1'b0;
      pulse_done();
      chk("wrap_pc", 32'(pc), 32'((k + 1) % 4));
    end

    // Asynchronous reset in the middle of ISSUE, then a stray done
    rom[0] = 16'h0123; rom[1] = 16'h0456;
    do_reset();
    enable = 1'b1;
    wait_run();
    pulse_done();
    wait_run();
    chk("async_pre_pc", 32'(pc), 32'd1);
    enable = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("async_run", 32'(bus.run), 32'd0);
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("async_instr", 32'(bus.instruction), 32'd0);
    #2;
    reset = 1'b1;
    pulse_done();
    chk("stray_done_run", 32'(bus.run), 32'd0);
    chk("stray_done_pc", 32'(pc), 32'd0);
    chk("stray_done_rd_en", 32'(bus.mem_rd_en), 32'd0);
    chk("stray_done_halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    chk("stray_done_idle_rd", 32'(bus.mem_rd_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
